// File: rtl/rf_arb_pkg.sv
// Shared widths and write-port source encoding for the register-file write arbiter.
package rf_arb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    WSRC_NONE = 2'd0,
    WSRC_W    = 2'd1,
    WSRC_LLU  = 2'd2
  } wsrc_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard of registers awaiting a long-latency result, plus the outstanding-op count.
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_a3,
  output logic              iss_ready,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_a3,
  input  logic [REG_AW-1:0] rd_a1,
  input  logic [REG_AW-1:0] rd_a2,
  output logic              rd_stall,
  input  logic [REG_AW-1:0] chk_a3,
  output logic              chk_busy
);
  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  logic [2**REG_AW-1:0] busy;
  logic [2**REG_AW-1:0] busy_next;
  logic [PEND_W-1:0]    pend_cnt;
  logic                 iss_fire;
  logic                 dec;

  // A second in-flight write to the same register is refused, so results never race.
  assign iss_ready = (pend_cnt < PEND_MAX) && !((iss_a3 != '0) && busy[iss_a3]);
  assign iss_fire  = iss_valid && iss_ready;
  assign dec       = clr_en && (pend_cnt != '0);

  assign rd_stall = ((rd_a1 != '0) && busy[rd_a1]) || ((rd_a2 != '0) && busy[rd_a2]);
  assign chk_busy = busy[chk_a3];

  // Clear first, then set, so a same-edge issue to the committing register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_a3] = 1'b0;
    if (iss_fire && (iss_a3 != '0)) busy_next[iss_a3] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= busy_next;
      case ({iss_fire, dec})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: W stage always wins, a one-entry hold buffers LLU results.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [REG_AW-1:0] w_a3,
  input  logic [DATA_W-1:0] w_wd,
  input  logic [DATA_W-1:0] w_pc,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_a3,
  output logic              iss_ready,
  input  logic              llu_valid,
  input  logic [REG_AW-1:0] llu_a3,
  input  logic [DATA_W-1:0] llu_wd,
  input  logic [DATA_W-1:0] llu_pc,
  output logic              llu_ready,
  input  logic [REG_AW-1:0] rd_a1,
  input  logic [REG_AW-1:0] rd_a2,
  output logic              rd_stall,
  output logic              force_bubble,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic [DATA_W-1:0] rf_pc,
  output logic              proto_err
);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic              hold_v;
  logic [REG_AW-1:0] hold_a3;
  logic [DATA_W-1:0] hold_wd;
  logic [DATA_W-1:0] hold_pc;
  logic [STARVE_W-1:0] starve_cnt;
  wsrc_e             wsrc;
  logic              commit;
  logic              llu_fire;
  logic              llu_busy;

  // No bypass from llu inputs to the port: a result always spends one cycle in the hold.
  assign llu_ready    = !hold_v;
  assign llu_fire     = llu_valid && !hold_v;
  assign commit       = (wsrc == WSRC_LLU);
  assign force_bubble = hold_v && (starve_cnt == STARVE_MAX);

  always_comb begin
    wsrc = WSRC_NONE;
    if (w_we)        wsrc = WSRC_W;
    else if (hold_v) wsrc = WSRC_LLU;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    rf_pc = '0;
    case (wsrc)
      WSRC_W: begin
        rf_we = 1'b1;
        rf_a3 = w_a3;
        rf_wd = w_wd;
        rf_pc = w_pc;
      end
      WSRC_LLU: begin
        rf_we = 1'b1;
        rf_a3 = hold_a3;
        rf_wd = hold_wd;
        rf_pc = hold_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v     <= 1'b0;
      hold_a3    <= '0;
      hold_wd    <= '0;
      hold_pc    <= '0;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (commit) hold_v <= 1'b0;
      if (llu_fire) begin
        hold_v  <= 1'b1;
        hold_a3 <= llu_a3;
        hold_wd <= llu_wd;
        hold_pc <= llu_pc;
      end
      if (commit) starve_cnt <= '0;
      else if (hold_v && w_we && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      // A result nobody was waiting for is flagged but still written.
      if (llu_fire && (llu_a3 != '0) && !llu_busy) proto_err <= 1'b1;
    end
  end

  rf_scoreboard #(
    .MAX_PEND(MAX_PEND)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_valid(iss_valid),
    .iss_a3   (iss_a3),
    .iss_ready(iss_ready),
    .clr_en   (commit),
    .clr_a3   (hold_a3),
    .rd_a1    (rd_a1),
    .rd_a2    (rd_a2),
    .rd_stall (rd_stall),
    .chk_a3   (llu_a3),
    .chk_busy (llu_busy)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios plus randomized traffic checked against a set/queue-based reference model.
module tb_rf_wb_arbiter;
  localparam int MAX_PEND     = 4;
  localparam int STARVE_LIMIT = 3;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we, iss_valid, llu_valid;
  logic [4:0]  w_a3, iss_a3, llu_a3, rd_a1, rd_a2;
  logic [31:0] w_wd, w_pc, llu_wd, llu_pc;
  logic        iss_ready, llu_ready, rd_stall, force_bubble, rf_we, proto_err;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, rf_pc;

  int compared   = 0;
  int mismatched = 0;

  int   m_pend;
  bit   m_busy[int];
  res_t m_hold[$];
  int   m_starve;
  bit   m_perr;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.MAX_PEND(MAX_PEND), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
    .iss_valid(iss_valid), .iss_a3(iss_a3), .iss_ready(iss_ready),
    .llu_valid(llu_valid), .llu_a3(llu_a3), .llu_wd(llu_wd), .llu_pc(llu_pc),
    .llu_ready(llu_ready),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_stall(rd_stall), .force_bubble(force_bubble),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_pc(rf_pc), .proto_err(proto_err)
  );

  function automatic bit m_is_busy(logic [4:0] r);
    return (r != 5'd0) && m_busy.exists(int'(r));
  endfunction

  function automatic bit exp_iss_ready();
    return (m_pend < MAX_PEND) && !m_is_busy(iss_a3);
  endfunction

  function automatic logic [74:0] expv();
    logic we;
    logic [4:0] a3;
    logic [31:0] wd, pc;
    we = 1'b0; a3 = '0; wd = '0; pc = '0;
    if (w_we) begin
      we = 1'b1; a3 = w_a3; wd = w_wd; pc = w_pc;
    end else if (m_hold.size() > 0) begin
      we = 1'b1; a3 = m_hold[0].a3; wd = m_hold[0].wd; pc = m_hold[0].pc;
    end
    return {exp_iss_ready(), m_hold.size() == 0, m_is_busy(rd_a1) || m_is_busy(rd_a2),
            (m_hold.size() > 0) && (m_starve == STARVE_LIMIT), we, a3, wd, pc, m_perr};
  endfunction

  function automatic logic [74:0] obs();
    return {iss_ready, llu_ready, rd_stall, force_bubble, rf_we,
            rf_we ? rf_a3 : 5'd0, rf_we ? rf_wd : 32'd0, rf_we ? rf_pc : 32'd0, proto_err};
  endfunction

  task automatic model_step();
    bit iss_acc, res_acc, commit;
    if (reset) begin
      m_pend = 0; m_busy.delete(); m_hold.delete(); m_starve = 0; m_perr = 0;
      return;
    end
    iss_acc = iss_valid && exp_iss_ready();
    res_acc = llu_valid && (m_hold.size() == 0);
    commit  = !w_we && (m_hold.size() > 0);
    if (res_acc && (llu_a3 != 5'd0) && !m_is_busy(llu_a3)) m_perr = 1'b1;
    if (commit) begin
      if (m_busy.exists(int'(m_hold[0].a3))) m_busy.delete(int'(m_hold[0].a3));
      if (m_pend > 0) m_pend--;
      void'(m_hold.pop_front());
      m_starve = 0;
    end else if ((m_hold.size() > 0) && w_we && (m_starve < STARVE_LIMIT)) begin
      m_starve++;
    end
    if (iss_acc) begin
      m_pend++;
      if (iss_a3 != 5'd0) m_busy[int'(iss_a3)] = 1'b1;
    end
    if (res_acc) m_hold.push_back('{llu_a3, llu_wd, llu_pc});
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
    iss_valid = 0; iss_a3 = 0;
    llu_valid = 0; llu_a3 = 0; llu_wd = 0; llu_pc = 0;
    rd_a1 = 0; rd_a2 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    compared++;
    if ({rf_we, rd_stall, force_bubble, iss_ready, llu_ready, proto_err} !== 6'b000110) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b expected 000110",
               {rf_we, rd_stall, force_bubble, iss_ready, llu_ready, proto_err});
    end
  endtask

  task automatic test_basic();
    do_reset();
    iss_valid = 1; iss_a3 = 5; rd_a1 = 5;
    settle();
    compared++;
    if (iss_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL basic_iss_ready: got %b expected 1", iss_ready);
    end
    tick();
    iss_valid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      compared++;
      if (rd_stall !== 1'b1) begin
        mismatched++; $display("[TB] FAIL basic_stall_wait%0d: got %b expected 1", k, rd_stall);
      end
      tick();
    end
    llu_valid = 1; llu_a3 = 5; llu_wd = 32'hDEADBEEF; llu_pc = 32'h0000_1040;
    settle();
    compared++;
    if (rf_we !== 1'b0) begin
      mismatched++; $display("[TB] FAIL basic_no_bypass: got rf_we=%b expected 0", rf_we);
    end
    tick();
    llu_valid = 0;
    settle();
    compared++;
    if ({rf_we, rf_a3, rf_wd, rf_pc, rd_stall} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h1040, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL basic_commit: got we=%b a3=%0d wd=%h pc=%h stall=%b expected 1 5 deadbeef 00001040 1",
               rf_we, rf_a3, rf_wd, rf_pc, rd_stall);
    end
    tick();
    settle();
    compared++;
    if ({rf_we, rd_stall} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL basic_after_commit: got we=%b stall=%b expected 0 0", rf_we, rd_stall);
    end
  endtask

  task automatic test_starve();
    do_reset();
    iss_valid = 1; iss_a3 = 3;
    tick();
    iss_valid = 0;
    llu_valid = 1; llu_a3 = 3; llu_wd = 32'hCAFE0003; llu_pc = 32'h2000;
    tick();
    llu_valid = 0;
    w_we = 1;
    for (int k = 0; k < 3; k++) begin
      w_a3 = 5'(16 + k); w_wd = 32'h1000 + 32'(k); w_pc = 32'h3000 + 32'(k);
      settle();
      compared++;
      if ({rf_we, rf_a3, rf_wd, force_bubble} !== {1'b1, 5'(16 + k), 32'h1000 + 32'(k), 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL starve_w_wins%0d: got we=%b a3=%0d wd=%h fb=%b expected 1 %0d %h 0",
                 k, rf_we, rf_a3, rf_wd, force_bubble, 16 + k, 32'h1000 + 32'(k));
      end
      tick();
    end
    w_we = 0;
    settle();
    compared++;
    if ({force_bubble, rf_we, rf_a3, rf_wd} !== {1'b1, 1'b1, 5'd3, 32'hCAFE0003}) begin
      mismatched++;
      $display("[TB] FAIL starve_bubble_commit: got fb=%b we=%b a3=%0d wd=%h expected 1 1 3 cafe0003",
               force_bubble, rf_we, rf_a3, rf_wd);
    end
    tick();
    settle();
    compared++;
    if ({force_bubble, rf_we, llu_ready} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL starve_cleared: got fb=%b we=%b llu_ready=%b expected 0 0 1", force_bubble, rf_we, llu_ready);
    end
  endtask

  task automatic test_full();
    do_reset();
    iss_valid = 1;
    for (int k = 0; k < 4; k++) begin
      iss_a3 = 5'(11 + k);
      settle();
      compared++;
      if (iss_ready !== 1'b1) begin
        mismatched++; $display("[TB] FAIL full_issue%0d: got %b expected 1", k, iss_ready);
      end
      tick();
    end
    iss_a3 = 15;
    settle();
    compared++;
    if (iss_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL full_fifth_blocked: got %b expected 0", iss_ready);
    end
    llu_valid = 1; llu_a3 = 11; llu_wd = 32'h11; llu_pc = 32'h44;
    tick();
    llu_valid = 0;
    settle();
    compared++;
    if (iss_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL full_commit_cycle: got %b expected 0", iss_ready);
    end
    tick();
    settle();
    compared++;
    if (iss_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL full_after_commit: got %b expected 1", iss_ready);
    end
    tick();
    iss_valid = 0;
  endtask

  task automatic test_waw();
    do_reset();
    iss_valid = 1; iss_a3 = 7;
    tick();
    settle();
    compared++;
    if (iss_ready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL waw_blocked: got %b expected 0", iss_ready);
    end
    iss_valid = 0;
    llu_valid = 1; llu_a3 = 7; llu_wd = 32'h77; llu_pc = 32'h700;
    tick();
    llu_valid = 0;
    iss_valid = 1; iss_a3 = 7;
    settle();
    compared++;
    if ({rf_we, rf_a3, iss_ready} !== {1'b1, 5'd7, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL waw_commit_edge: got we=%b a3=%0d iss_ready=%b expected 1 7 0", rf_we, rf_a3, iss_ready);
    end
    tick();
    settle();
    compared++;
    if (iss_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL waw_after_clear: got %b expected 1", iss_ready);
    end
    tick();
    iss_valid = 0; rd_a1 = 7;
    settle();
    compared++;
    if ((rd_stall !== 1'b1) || (obs() !== expv())) begin
      mismatched++; $display("[TB] FAIL waw_rebusy: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_proto_zero();
    do_reset();
    llu_valid = 1; llu_a3 = 9; llu_wd = 32'h99; llu_pc = 32'h900;
    tick();
    llu_valid = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      compared++;
      if (proto_err !== 1'b1) begin
        mismatched++; $display("[TB] FAIL proto_sticky%0d: got %b expected 1", k, proto_err);
      end
      tick();
    end
    iss_valid = 1; iss_a3 = 0;
    tick();
    iss_valid = 0; rd_a1 = 0; rd_a2 = 0;
    settle();
    compared++;
    if ({rd_stall, iss_ready, proto_err} !== 3'b011) begin
      mismatched++;
      $display("[TB] FAIL zero_no_stall: got stall=%b iss_ready=%b perr=%b expected 0 1 1", rd_stall, iss_ready, proto_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    iss_valid = 1; iss_a3 = 2;
    tick();
    iss_a3 = 4;
    tick();
    iss_valid = 0;
    llu_valid = 1; llu_a3 = 2; llu_wd = 32'h22; llu_pc = 32'h200; w_we = 1; w_a3 = 1;
    tick();
    llu_valid = 0; w_we = 0;
    reset = 1;
    tick();
    reset = 0; rd_a1 = 4; rd_a2 = 2;
    settle();
    compared++;
    if ({rf_we, rd_stall, iss_ready, llu_ready} !== 4'b0011) begin
      mismatched++;
      $display("[TB] FAIL reset_mid: got we=%b stall=%b iss_ready=%b llu_ready=%b expected 0 0 1 1",
               rf_we, rd_stall, iss_ready, llu_ready);
    end
  endtask

  task automatic test_random();
    res_t outq[$];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      w_we = ($urandom_range(0, 99) < 55);
      w_a3 = 5'($urandom); w_wd = $urandom; w_pc = $urandom;
      iss_valid = ($urandom_range(0, 99) < 35);
      iss_a3 = 5'($urandom_range(0, 31));
      llu_valid = (outq.size() > 0) && ($urandom_range(0, 99) < 50);
      if (outq.size() > 0) begin
        llu_a3 = outq[0].a3; llu_wd = outq[0].wd; llu_pc = outq[0].pc;
      end else begin
        llu_a3 = 5'($urandom); llu_wd = $urandom; llu_pc = $urandom;
      end
      rd_a1 = 5'($urandom); rd_a2 = 5'($urandom);
      settle();
      compared++;
      if (obs() !== expv()) begin
        mismatched++; $display("[TB] FAIL random_cyc%0d: got %h expected %h", c, obs(), expv());
      end
      if (llu_valid && (m_hold.size() == 0)) void'(outq.pop_front());
      if (iss_valid && exp_iss_ready()) outq.push_back('{iss_a3, $urandom, $urandom});
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    m_pend = 0; m_starve = 0; m_perr = 0;
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_waw();
    test_proto_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
